// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS-subset control path.
// Opcodes, ALUOp codes, datapath select codes and FSM state numbering.
package mips_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // Must stay in step with alu_control.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    function automatic logic op_legal(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-word decoder: state and mem_ready in, datapath
// selects, strobes and the retire pulse out. en=0 forces every output low.
module mc_output_decode
    import mips_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    input  logic       en,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic [1:0] PCSource,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       instr_done
);

    always_comb begin
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        PCSource   = PCSRC_ALU;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RT;
        ALUOp      = ALUOP_ADD;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        instr_done = 1'b0;
        if (en) begin
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: ALUSrcB = SRCB_IMMSH;
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    MemtoReg   = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    RegDst     = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA    = 1'b1;
                    ALUOp      = ALUOP_SUB;
                    Branch     = 1'b1;
                    PCSource   = PCSRC_ALUOUT;
                    instr_done = 1'b1;
                end
                S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_ADDIWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = PCSRC_JUMP;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle main control FSM: state register, DECODE opcode latch and the
// sticky illegal-opcode flag; the control word comes from mc_output_decode.
module main_control_fsm
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic [1:0] PCSource,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    state_t     state, state_nx;
    logic [5:0] op_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FETCH;
            op_q       <= '0;
            illegal_op <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE) begin
                op_q <= opcode;
                if (!op_legal(opcode))
                    illegal_op <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = S_FETCH;
        case (state)
            S_FETCH:  state_nx = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (1'b1)
                    (opcode == OP_LW),
                    (opcode == OP_SW):   state_nx = S_MEMADR;
                    (opcode == OP_R):    state_nx = S_EXEC;
                    (opcode == OP_BEQ):  state_nx = S_BRANCH;
                    (opcode == OP_J):    state_nx = S_JUMP;
                    (opcode == OP_ADDI): state_nx = S_ADDIEX;
                    default:             state_nx = S_FETCH;
                endcase
            end
            // opcode is only valid in DECODE, so use the latched copy.
            S_MEMADR: begin
                if (op_q == OP_LW)
                    state_nx = S_MEMRD;
                else if (op_q == OP_SW)
                    state_nx = S_MEMWR;
                else
                    state_nx = S_FETCH;
            end
            S_MEMRD:  state_nx = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_nx = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_nx = S_ALUWB;
            S_ADDIEX: state_nx = S_ADDIWB;
            default:  state_nx = S_FETCH;
        endcase
    end

    assign state_dbg = rst ? 4'd0 : state;

    mc_output_decode u_dec (
        .state      (state),
        .mem_ready  (mem_ready),
        .en         (~rst),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .Branch     (Branch),
        .PCSource   (PCSource),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .instr_done (instr_done)
    );

endmodule
